ex_muladd: RTL and testbench

//  EX-stage HI/LO arithmetic unit; feeds the MEM stage (ex_* outputs).

---
 rtl/ex_muladd.sv | 185 ++++++++++++++++++
 tb/tb_ex_muladd.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muladd.sv
// EX-stage HI/LO multiply / multiply-accumulate unit with stall request to ctrl.
// Optional build macro MULADD_ITER_EN selects a radix-2 iterative multiplier.
module ex_muladd #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              op_valid_i,
  input  logic [2:0]        op_i,
  input  logic [DW-1:0]     src_a_i,
  input  logic [DW-1:0]     src_b_i,
  input  logic [DW-1:0]     hi_i,
  input  logic [DW-1:0]     lo_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DW-1:0]     wdata_i,
  output logic              ex_we,
  output logic [AW-1:0]     ex_waddr,
  output logic [DW-1:0]     ex_wdata,
  output logic              ex_whilo,
  output logic [DW-1:0]     ex_hi,
  output logic [DW-1:0]     ex_lo,
  output logic [4:0]        ex_cnt,
  output logic [2*DW-1:0]   ex_hilo_tempt,
  output logic              stallreq
);

  localparam int HW = 2 * DW;

`ifdef MULADD_ITER_EN
  typedef enum logic [1:0] {S_IDLE, S_ACC, S_MUL, S_DONE} state_t;
`else
  typedef enum logic {S_IDLE, S_ACC} state_t;
`endif

  state_t          r_state;
  logic [HW-1:0]   r_temp;
  logic [4:0]      r_cnt;

  logic            w_is_mul;
  logic            w_is_madd;
  logic            w_is_sub;
  logic [HW-1:0]   w_hilo_in;
  logic            w_stallreq;
  logic            w_whilo;
  logic [HW-1:0]   w_hilo;

  function automatic logic [HW-1:0] f_accum(input logic sub, input logic [HW-1:0] base,
                                            input logic [HW-1:0] term);
    f_accum = sub ? (base - term) : (base + term);
  endfunction

  assign w_is_mul  = op_valid_i && (op_i == 3'd1 || op_i == 3'd2);
  assign w_is_madd = op_valid_i && (op_i >= 3'd3 && op_i <= 3'd6);
  assign w_is_sub  = (op_i == 3'd5 || op_i == 3'd6);
  assign w_hilo_in = {hi_i, lo_i};

`ifdef MULADD_ITER_EN
  function automatic logic [DW-1:0] f_mag(input logic sgn, input logic [DW-1:0] v);
    f_mag = (sgn && v[DW-1]) ? (~v + 1'b1) : v;
  endfunction

  logic [DW-1:0]   w_abs_a;
  logic [DW-1:0]   w_abs_b;
  logic            w_neg;
  logic [HW-1:0]   w_partial;

  assign w_abs_a   = f_mag(op_i[0], src_a_i);
  assign w_abs_b   = f_mag(op_i[0], src_b_i);
  assign w_neg     = op_i[0] & (src_a_i[DW-1] ^ src_b_i[DW-1]);
  // One multiplier bit per cycle; r_cnt doubles as the bit index.
  assign w_partial = r_temp + (w_abs_b[r_cnt] ? ({{DW{1'b0}}, w_abs_a} << r_cnt) : '0);
`else
  function automatic logic [HW-1:0] f_product(input logic sgn, input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
    logic signed [HW-1:0] sa;
    logic signed [HW-1:0] sb;
    sa = sgn ? {{DW{a[DW-1]}}, a} : {{DW{1'b0}}, a};
    sb = sgn ? {{DW{b[DW-1]}}, b} : {{DW{1'b0}}, b};
    f_product = sa * sb;
  endfunction

  logic [HW-1:0]   w_product;
  assign w_product = f_product(op_i[0], src_a_i, src_b_i);
`endif

  always_comb begin
    w_stallreq = 1'b0;
    w_whilo    = 1'b0;
    w_hilo     = '0;
    case (r_state)
      S_IDLE: begin
`ifdef MULADD_ITER_EN
        w_stallreq = w_is_mul || w_is_madd;
`else
        if (w_is_mul) begin
          w_whilo = 1'b1;
          w_hilo  = w_product;
        end else begin
          w_stallreq = w_is_madd;
        end
`endif
      end
      S_ACC: begin
        w_whilo = 1'b1;
        w_hilo  = f_accum(w_is_sub, w_hilo_in, r_temp);
      end
`ifdef MULADD_ITER_EN
      S_MUL: w_stallreq = 1'b1;
      S_DONE: begin
        w_whilo = 1'b1;
        w_hilo  = r_temp;
      end
`endif
    endcase
    if (flush_i) begin
      w_stallreq = 1'b0;
      w_whilo    = 1'b0;
      w_hilo     = '0;
    end
  end

  // Outputs are forced to zero for the whole time reset is held.
  assign ex_we         = !reset && we_i && op_valid_i && !w_stallreq && !flush_i;
  assign ex_waddr      = reset ? '0 : waddr_i;
  assign ex_wdata      = reset ? '0 : wdata_i;
  assign ex_whilo      = !reset && w_whilo;
  assign ex_hi         = reset ? '0 : w_hilo[HW-1:DW];
  assign ex_lo         = reset ? '0 : w_hilo[DW-1:0];
  assign stallreq      = !reset && w_stallreq;
  assign ex_cnt        = reset ? '0 : r_cnt;
  assign ex_hilo_tempt = reset ? '0 : r_temp;

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      r_state <= S_IDLE;
      r_temp  <= '0;
      r_cnt   <= '0;
    end else if (!stall_i) begin
      case (r_state)
        S_IDLE: begin
`ifdef MULADD_ITER_EN
          if (w_is_mul || w_is_madd) begin
            r_temp  <= w_partial;
            r_cnt   <= 5'd1;
            r_state <= S_MUL;
          end
`else
          if (w_is_madd) begin
            r_temp  <= w_product;
            r_cnt   <= 5'd1;
            r_state <= S_ACC;
          end
`endif
        end
        S_ACC: begin
          r_temp  <= '0;
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
`ifdef MULADD_ITER_EN
        S_MUL: begin
          if (r_cnt == 5'd31) begin
            r_temp  <= w_neg ? (~w_partial + 1'b1) : w_partial;
            r_cnt   <= 5'd1;
            r_state <= (op_i == 3'd1 || op_i == 3'd2) ? S_DONE : S_ACC;
          end else begin
            r_temp <= w_partial;
            r_cnt  <= r_cnt + 5'd1;
          end
        end
        S_DONE: begin
          r_temp  <= '0;
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
`endif
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muladd.sv
`timescale 1ns/1ps
module tb_ex_muladd;

  logic        clk = 1'b0;
  logic        reset, stall_i, flush_i, op_valid_i, we_i;
  logic [2:0]  op_i;
  logic [31:0] src_a_i, src_b_i, hi_i, lo_i, wdata_i;
  logic [4:0]  waddr_i;
  logic        ex_we, ex_whilo, stallreq;
  logic [4:0]  ex_waddr, ex_cnt;
  logic [31:0] ex_wdata, ex_hi, ex_lo;
  logic [63:0] ex_hilo_tempt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ex_muladd #(.DW(32), .AW(5)) dut (
    .clk(clk), .reset(reset), .stall_i(stall_i), .flush_i(flush_i),
    .op_valid_i(op_valid_i), .op_i(op_i), .src_a_i(src_a_i), .src_b_i(src_b_i),
    .hi_i(hi_i), .lo_i(lo_i), .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
    .ex_we(ex_we), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata), .ex_whilo(ex_whilo),
    .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_cnt(ex_cnt), .ex_hilo_tempt(ex_hilo_tempt),
    .stallreq(stallreq)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_prod(input int op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    if (op % 2 == 1) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    return 64'(sa * sb);
  endfunction

  function automatic logic [63:0] ref_acc(input int op, input logic [31:0] h, input logic [31:0] l,
                                          input logic [63:0] p);
    if (op == 5 || op == 6) return {h, l} - p;
    return {h, l} + p;
  endfunction

  task automatic drive(input logic v, input int op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] h, input logic [31:0] l);
    op_valid_i = v; op_i = 3'(op); src_a_i = a; src_b_i = b; hi_i = h; lo_i = l;
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  logic [63:0] exp_p, exp_r;
  int          op, nst;
  logic [31:0] ra, rb, rh, rl;
  logic        rwe;

  initial begin
    reset = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
    we_i = 1'b1; waddr_i = 5'd7; wdata_i = 32'd123;
    drive(1'b1, 1, 32'd3, 32'd5, 32'd0, 32'd0);
    nxt(); nxt();
    @(negedge clk);
    chk("rst_we", ex_we, 1'b0);
    chk("rst_whilo", ex_whilo, 1'b0);
    chk("rst_hi", ex_hi, 32'd0);
    chk("rst_lo", ex_lo, 32'd0);
    chk("rst_stall", stallreq, 1'b0);
    chk("rst_cnt", ex_cnt, 5'd0);
    chk("rst_temp", ex_hilo_tempt, 64'd0);
    chk("rst_waddr", ex_waddr, 5'd0);
    chk("rst_wdata", ex_wdata, 32'd0);
    nxt();
    reset = 1'b0;

    drive(1'b1, 0, 32'd1, 32'd2, 32'd0, 32'd0);
    @(negedge clk);
    chk("nop_we", ex_we, 1'b1);
    chk("nop_waddr", ex_waddr, 5'd7);
    chk("nop_wdata", ex_wdata, 32'd123);
    chk("nop_whilo", ex_whilo, 1'b0);
    nxt();

    we_i = 1'b0;
    drive(1'b1, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0);
    @(negedge clk);
    chk("multu_hi", ex_hi, 32'hFFFF_FFFE);
    chk("multu_lo", ex_lo, 32'h0000_0001);
    chk("multu_whilo", ex_whilo, 1'b1);
    chk("multu_stall", stallreq, 1'b0);
    nxt();

    we_i = 1'b1;
    drive(1'b1, 3, 32'hFFFF_FFFE, 32'd3, 32'd0, 32'd5);
    @(negedge clk);
    chk("madd_c0_stall", stallreq, 1'b1);
    chk("madd_c0_we", ex_we, 1'b0);
    chk("madd_c0_whilo", ex_whilo, 1'b0);
    nxt();
    @(negedge clk);
    chk("madd_c1_temp", ex_hilo_tempt, 64'hFFFF_FFFF_FFFF_FFFA);
    chk("madd_c1_hi", ex_hi, 32'hFFFF_FFFF);
    chk("madd_c1_lo", ex_lo, 32'hFFFF_FFFF);
    chk("madd_c1_whilo", ex_whilo, 1'b1);
    chk("madd_c1_stall", stallreq, 1'b0);
    nxt();
    we_i = 1'b0;

    drive(1'b1, 6, 32'd2, 32'd3, 32'd0, 32'd10);
    nxt();
    @(negedge clk);
    chk("msubu_hi", ex_hi, 32'd0);
    chk("msubu_lo", ex_lo, 32'd4);
    chk("msubu_whilo", ex_whilo, 1'b1);
    chk("msubu_cnt", ex_cnt, 5'd1);
    nxt();
    drive(1'b0, 0, 32'd0, 32'd0, 32'd0, 32'd0);
    @(negedge clk);
    chk("msubu_c2_cnt", ex_cnt, 5'd0);
    chk("msubu_c2_whilo", ex_whilo, 1'b0);
    nxt();

    drive(1'b1, 4, 32'd9, 32'd9, 32'd0, 32'd0);
    stall_i = 1'b1;
    nxt();
    @(negedge clk);
    chk("stidle_temp", ex_hilo_tempt, 64'd0);
    chk("stidle_stall", stallreq, 1'b1);
    stall_i = 1'b0;
    nxt();
    nxt();

    drive(1'b1, 3, 32'd100, 32'hFFFF_FFF6, 32'd0, 32'd2000);
    exp_r = ref_acc(3, 32'd0, 32'd2000, ref_prod(3, 32'd100, 32'hFFFF_FFF6));
    nxt();
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if ({ex_hi, ex_lo} !== exp_r) begin
        miscompares++;
        $error("FAIL stacc_hilo observed=%0h expected=%0h", {ex_hi, ex_lo}, exp_r);
      end
      vectors++;
      if (ex_cnt !== 5'd1) begin
        miscompares++;
        $error("FAIL stacc_cnt observed=%0h expected=%0h", ex_cnt, 5'd1);
      end
      nxt();
    end
    stall_i = 1'b0;
    @(negedge clk);
    chk("stacc_rel_whilo", ex_whilo, 1'b1);
    nxt();
    drive(1'b0, 0, 32'd0, 32'd0, 32'd0, 32'd0);
    @(negedge clk);
    chk("stacc_idle_cnt", ex_cnt, 5'd0);
    chk("stacc_idle_whilo", ex_whilo, 1'b0);
    nxt();

    drive(1'b1, 5, 32'd7, 32'd7, 32'd0, 32'd100);
    we_i = 1'b1;
    nxt();
    flush_i = 1'b1;
    @(negedge clk);
    chk("flush_whilo", ex_whilo, 1'b0);
    chk("flush_we", ex_we, 1'b0);
    chk("flush_stall", stallreq, 1'b0);
    nxt();
    flush_i = 1'b0;
    drive(1'b0, 0, 32'd0, 32'd0, 32'd0, 32'd0);
    @(negedge clk);
    chk("postflush_cnt", ex_cnt, 5'd0);
    chk("postflush_temp", ex_hilo_tempt, 64'd0);
    chk("postflush_whilo", ex_whilo, 1'b0);
    nxt();

    drive(1'b1, 4, 32'd11, 32'd13, 32'd1, 32'd1);
    nxt();
    reset = 1'b1;
    @(negedge clk);
    chk("rstacc_whilo", ex_whilo, 1'b0);
    chk("rstacc_hi", ex_hi, 32'd0);
    chk("rstacc_we", ex_we, 1'b0);
    nxt();
    reset = 1'b0;
    drive(1'b0, 0, 32'd0, 32'd0, 32'd0, 32'd0);
    @(negedge clk);
    chk("postrst_cnt", ex_cnt, 5'd0);
    chk("postrst_temp", ex_hilo_tempt, 64'd0);
    chk("postrst_whilo", ex_whilo, 1'b0);
    nxt();

    for (int n = 0; n < 40; n++) begin
      op = int'($urandom_range(0, 7));
      ra = $urandom; rb = $urandom; rh = $urandom; rl = $urandom;
      rwe = 1'($urandom_range(0, 1));
      we_i = rwe;
      drive(1'b1, op, ra, rb, rh, rl);
      exp_p = ref_prod(op, ra, rb);
      @(negedge clk);
      if (op == 1 || op == 2) begin
        vectors++;
        if ({ex_hi, ex_lo} !== exp_p) begin
          miscompares++;
          $error("FAIL rnd_mul_hilo observed=%0h expected=%0h", {ex_hi, ex_lo}, exp_p);
        end
        vectors++;
        if (ex_whilo !== 1'b1) begin
          miscompares++;
          $error("FAIL rnd_mul_whilo observed=%0h expected=%0h", ex_whilo, 1'b1);
        end
        vectors++;
        if (ex_we !== rwe) begin
          miscompares++;
          $error("FAIL rnd_mul_we observed=%0h expected=%0h", ex_we, rwe);
        end
      end else if (op >= 3 && op <= 6) begin
        vectors++;
        if (stallreq !== 1'b1) begin
          miscompares++;
          $error("FAIL rnd_madd_stall observed=%0h expected=%0h", stallreq, 1'b1);
        end
        vectors++;
        if (ex_we !== 1'b0) begin
          miscompares++;
          $error("FAIL rnd_madd_we observed=%0h expected=%0h", ex_we, 1'b0);
        end
        exp_r = ref_acc(op, rh, rl, exp_p);
        nxt();
        nst = int'($urandom_range(0, 2));
        stall_i = 1'b1;
        for (int s = 0; s < nst; s++) begin
          @(negedge clk);
          vectors++;
          if ({ex_hi, ex_lo} !== exp_r) begin
            miscompares++;
            $error("FAIL rnd_acc_hold observed=%0h expected=%0h", {ex_hi, ex_lo}, exp_r);
          end
          nxt();
        end
        stall_i = 1'b0;
        @(negedge clk);
        vectors++;
        if ({ex_hi, ex_lo} !== exp_r) begin
          miscompares++;
          $error("FAIL rnd_acc_hilo observed=%0h expected=%0h", {ex_hi, ex_lo}, exp_r);
        end
        vectors++;
        if (ex_whilo !== 1'b1) begin
          miscompares++;
          $error("FAIL rnd_acc_whilo observed=%0h expected=%0h", ex_whilo, 1'b1);
        end
        vectors++;
        if (stallreq !== 1'b0) begin
          miscompares++;
          $error("FAIL rnd_acc_stall observed=%0h expected=%0h", stallreq, 1'b0);
        end
      end else begin
        vectors++;
        if (ex_whilo !== 1'b0) begin
          miscompares++;
          $error("FAIL rnd_nop_whilo observed=%0h expected=%0h", ex_whilo, 1'b0);
        end
        vectors++;
        if ({ex_hi, ex_lo} !== 64'd0) begin
          miscompares++;
          $error("FAIL rnd_nop_hilo observed=%0h expected=%0h", {ex_hi, ex_lo}, 64'd0);
        end
        vectors++;
        if (ex_we !== rwe) begin
          miscompares++;
          $error("FAIL rnd_nop_we observed=%0h expected=%0h", ex_we, rwe);
        end
      end
      nxt();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end

endmodule
